// File: rtl/tournament_req4_pkg.sv
// Shared types and constants for the base-4 tournament requester front end.
// The age parameters are only used when TOURNAMENT_AGING_EN is defined.
package tournament_req4_pkg;

    localparam int WIDTH_UNITS = 4;
    localparam int NUM_PORTS   = 4;
    localparam int AGE_PERIOD  = 8;
    localparam int AGE_WIDTH   = $clog2(AGE_PERIOD) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GNT  = 2'd2
    } slot_state_t;

    typedef logic [WIDTH_UNITS:0]   tour_entry_t;
    typedef logic [WIDTH_UNITS-1:0] prio_t;

    function automatic prio_t prio_sat_inc(input prio_t p);
        return (p == {WIDTH_UNITS{1'b1}}) ? p : p + prio_t'(1);
    endfunction

    function automatic logic [NUM_PORTS-1:0] lowest_one(input logic [NUM_PORTS-1:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/tournament_req4_if.sv
// Requester/selector signal bundle for tournament_req4; the slave modport is the block itself.
interface tournament_req4_if;
    import tournament_req4_pkg::*;

    logic [3:0]        req;
    prio_t       [3:0] prio;
    logic [3:0]        ack;
    tour_entry_t [3:0] entry;
    logic              sel_valid;
    logic [3:0]        win;
    logic [3:0]        grant;
    logic [1:0]        grant_no;
    logic              busy;
    logic              err;

    modport master (output req, prio, sel_valid, win,
                    input  ack, entry, grant, grant_no, busy, err);
    modport slave  (input  req, prio, sel_valid, win,
                    output ack, entry, grant, grant_no, busy, err);
endinterface

// File: rtl/tournament_req4_slot.sv
// One requester slot: IDLE -> WAIT -> GNT FSM, captured priority and optional age counter.
// Aging is compiled in with TOURNAMENT_AGING_EN.
module tournament_req4_slot
    import tournament_req4_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  prio_t       prio,
    input  logic        win,
    output logic        ack,
    output tour_entry_t entry,
    output logic        in_wait,
    output logic        grant
);

    slot_state_t state_r;
    slot_state_t state_s;
    prio_t       prio_r;
    logic        capture_s;

    // Next-state logic; requests are only taken from IDLE so a GNT cycle always separates grants.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (req) state_s = WAIT; else state_s = IDLE;
            WAIT:    if (win) state_s = GNT;  else state_s = WAIT;
            GNT:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    assign capture_s = (state_r == IDLE) && req;

`ifdef TOURNAMENT_AGING_EN
    localparam logic [AGE_WIDTH-1:0] AGE_LAST = AGE_WIDTH'(AGE_PERIOD - 1);
    logic [AGE_WIDTH-1:0] age_r;

    // Priority capture plus aging: a full age period in WAIT bumps the priority, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_r <= {WIDTH_UNITS{1'b0}};
            age_r  <= {AGE_WIDTH{1'b0}};
        end else if (capture_s) begin
            prio_r <= prio;
            age_r  <= {AGE_WIDTH{1'b0}};
        end else if (state_r == WAIT) begin
            if (age_r == AGE_LAST) begin
                age_r  <= {AGE_WIDTH{1'b0}};
                prio_r <= prio_sat_inc(prio_r);
            end else begin
                age_r  <= age_r + {{(AGE_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            age_r <= {AGE_WIDTH{1'b0}};
        end
    end
`else
    // Priority captured on acknowledge and held static.
    always_ff @(posedge clock) begin
        if (reset)          prio_r <= {WIDTH_UNITS{1'b0}};
        else if (capture_s) prio_r <= prio;
        else                prio_r <= prio_r;
    end
`endif

    // Ack is gated by reset so that a request held through reset is not acknowledged.
    assign ack     = capture_s && !reset;
    assign in_wait = (state_r == WAIT);
    assign grant   = (state_r == GNT);
    assign entry   = in_wait ? {1'b1, prio_r} : {(WIDTH_UNITS+1){1'b0}};

endmodule

// File: rtl/tournament_req4.sv
// Requester-side front end for the base-4 tournament selector.
// Optional priority aging is enabled by defining TOURNAMENT_AGING_EN.
module tournament_req4
    import tournament_req4_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    tournament_req4_if.slave  bus
);

    logic [3:0]  wait_mask_s;
    logic [3:0]  first_win_s;
    logic [3:0]  accept_s;
    logic [3:0]  ack_s;
    logic [3:0]  grant_s;
    logic        err_set_s;
    logic        err_r;
    logic [1:0]  grant_no_s;
    tour_entry_t entry_s [NUM_PORTS];

    // Lowest-index win filter and protocol error detection; flags are ignored without sel_valid.
    always_comb begin
        first_win_s = lowest_one(bus.win);
        accept_s    = 4'b0000;
        err_set_s   = 1'b0;
        if (bus.sel_valid) begin
            accept_s  = first_win_s & wait_mask_s;
            err_set_s = (bus.win == 4'b0000) || (bus.win != first_win_s) ||
                        ((bus.win & ~wait_mask_s) != 4'b0000);
        end else begin
            accept_s  = 4'b0000;
            err_set_s = 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        tournament_req4_slot u_slot (
            .clock   (clock),
            .reset   (reset),
            .req     (bus.req[g]),
            .prio    (bus.prio[g]),
            .win     (accept_s[g]),
            .ack     (ack_s[g]),
            .entry   (entry_s[g]),
            .in_wait (wait_mask_s[g]),
            .grant   (grant_s[g])
        );
        assign bus.entry[g] = entry_s[g];
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset)          err_r <= 1'b0;
        else if (err_set_s) err_r <= 1'b1;
        else                err_r <= err_r;
    end

    // Grant index; at most one slot is in GNT because only one win is accepted per cycle.
    always_comb begin
        grant_no_s = 2'd0;
        case (grant_s)
            4'b0010: grant_no_s = 2'd1;
            4'b0100: grant_no_s = 2'd2;
            4'b1000: grant_no_s = 2'd3;
            default: grant_no_s = 2'd0;
        endcase
    end

    assign bus.ack      = ack_s;
    assign bus.grant    = grant_s;
    assign bus.grant_no = grant_no_s;
    assign bus.busy     = |wait_mask_s;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_tournament_req4.sv
// Self-checking bench for tournament_req4: per-cycle vector table, grant scoreboard, aging sequence.
module tb_tournament_req4;
    import tournament_req4_pkg::*;

    logic clock;
    logic reset;
    tournament_req4_if bus ();

    tournament_req4 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] prio;
        logic        val;
        logic [3:0]  win;
        int          push;
        logic [3:0]  ack;
        logic [3:0]  grant;
        logic [1:0]  gno;
        logic        busy;
        logic        err;
        logic [19:0] ent;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];
    int   sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef TOURNAMENT_AGING_EN
    localparam logic [3:0] EXP_MID  = 4'd3;
    localparam logic [3:0] EXP_AGED = 4'd4;
`else
    localparam logic [3:0] EXP_MID  = 4'd2;
    localparam logic [3:0] EXP_AGED = 4'd2;
`endif

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [15:0] prio,
                                input logic val, input logic [3:0] win, input int push,
                                input logic [3:0] ack, input logic [3:0] grant, input logic [1:0] gno,
                                input logic busy, input logic err, input logic [19:0] ent);
        vec_t v;
        v.rst = rst; v.req = req; v.prio = prio; v.val = val; v.win = win; v.push = push;
        v.ack = ack; v.grant = grant; v.gno = gno; v.busy = busy; v.err = err; v.ent = ent;
        return v;
    endfunction

    function automatic logic [19:0] ents(input logic [4:0] e3, input logic [4:0] e2,
                                         input logic [4:0] e1, input logic [4:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [15:0] prio,
                         input logic val, input logic [3:0] win);
        reset         = rst;
        bus.req       = req;
        bus.prio      = prio;
        bus.sel_valid = val;
        bus.win       = win;
    endtask

    initial begin
        logic [19:0] ent_act;

        // Inputs for cycle i are applied after the falling edge; outputs sampled 1 unit later.
        tbl[0]  = mk(1, 4'hF, 16'h4321, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 0, 0, 20'h0);
        tbl[1]  = mk(1, 4'hF, 16'h4321, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 0, 0, 20'h0);
        tbl[2]  = mk(1, 4'hF, 16'h4321, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 0, 0, 20'h0);
        tbl[3]  = mk(0, 4'hF, 16'h4321, 0, 4'h0, -1, 4'hF, 4'h0, 2'd0, 0, 0, 20'h0);
        tbl[4]  = mk(0, 4'h0, 16'h4321, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 1, 0,
                     ents(5'h14, 5'h13, 5'h12, 5'h11));
        tbl[5]  = mk(0, 4'h0, 16'h4321, 1, 4'h2,  1, 4'h0, 4'h0, 2'd0, 1, 0,
                     ents(5'h14, 5'h13, 5'h12, 5'h11));
        tbl[6]  = mk(0, 4'h2, 16'h4371, 0, 4'h0, -1, 4'h0, 4'h2, 2'd1, 1, 0,
                     ents(5'h14, 5'h13, 5'h00, 5'h11));
        tbl[7]  = mk(0, 4'h2, 16'h4371, 0, 4'h0, -1, 4'h2, 4'h0, 2'd0, 1, 0,
                     ents(5'h14, 5'h13, 5'h00, 5'h11));
        tbl[8]  = mk(0, 4'h0, 16'h4371, 1, 4'h9,  0, 4'h0, 4'h0, 2'd0, 1, 0,
                     ents(5'h14, 5'h13, 5'h17, 5'h11));
        tbl[9]  = mk(0, 4'h0, 16'h4371, 0, 4'h0, -1, 4'h0, 4'h1, 2'd0, 1, 1,
                     ents(5'h14, 5'h13, 5'h17, 5'h00));
        tbl[10] = mk(0, 4'h0, 16'h4371, 0, 4'hF, -1, 4'h0, 4'h0, 2'd0, 1, 1,
                     ents(5'h14, 5'h13, 5'h17, 5'h00));
        tbl[11] = mk(1, 4'h0, 16'h4371, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 1, 1,
                     ents(5'h14, 5'h13, 5'h17, 5'h00));
        tbl[12] = mk(0, 4'h0, 16'h0000, 1, 4'h4, -1, 4'h0, 4'h0, 2'd0, 0, 0, 20'h0);
        tbl[13] = mk(0, 4'h0, 16'h0000, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 0, 1, 20'h0);
        tbl[14] = mk(1, 4'h0, 16'h0000, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 0, 1, 20'h0);
        tbl[15] = mk(0, 4'h4, 16'h0500, 0, 4'h0, -1, 4'h4, 4'h0, 2'd0, 0, 0, 20'h0);
        tbl[16] = mk(0, 4'h0, 16'h0500, 1, 4'h4,  2, 4'h0, 4'h0, 2'd0, 1, 0,
                     ents(5'h00, 5'h15, 5'h00, 5'h00));
        tbl[17] = mk(1, 4'h0, 16'h0500, 0, 4'h0, -1, 4'h0, 4'h4, 2'd2, 0, 0, 20'h0);
        tbl[18] = mk(0, 4'h0, 16'h0000, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 0, 0, 20'h0);
        tbl[19] = mk(0, 4'h0, 16'h0000, 0, 4'h0, -1, 4'h0, 4'h0, 2'd0, 0, 0, 20'h0);

        drive(1'b1, 4'h0, 16'h0000, 1'b0, 4'h0);
        repeat (2) @(posedge clock);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(tbl[i].rst, tbl[i].req, tbl[i].prio, tbl[i].val, tbl[i].win);
            #1;
            ent_act = bus.entry;
            check($sformatf("row%0d ack", i),      32'(bus.ack),      32'(tbl[i].ack));
            check($sformatf("row%0d grant", i),    32'(bus.grant),    32'(tbl[i].grant));
            check($sformatf("row%0d grant_no", i), 32'(bus.grant_no), 32'(tbl[i].gno));
            check($sformatf("row%0d busy", i),     32'(bus.busy),     32'(tbl[i].busy));
            check($sformatf("row%0d err", i),      32'(bus.err),      32'(tbl[i].err));
            for (int s = 0; s < 4; s++)
                check($sformatf("row%0d entry%0d", i, s),
                      32'(ent_act[s*5 +: 5]), 32'(tbl[i].ent[s*5 +: 5]));
            if (tbl[i].push >= 0) sb_q.push_back(tbl[i].push);
            if (bus.grant != 4'h0) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("row%0d unexpected grant", i), 32'(bus.grant), 32'h0);
                end else begin
                    int idx;
                    idx = sb_q.pop_front();
                    check($sformatf("row%0d sb grant", i), 32'(bus.grant), 32'(4'h1 << idx));
                end
            end
        end
        check("sb pending grants", 32'(sb_q.size()), 32'd0);

        // Aging sequence: slot 1 waits without wins, first with prio 2, then with all-ones.
        for (int pass = 0; pass < 2; pass++) begin
            logic [3:0] p0;
            logic [3:0] e_mid;
            logic [3:0] e_end;
            p0    = (pass == 0) ? 4'd2 : 4'hF;
            e_mid = (pass == 0) ? EXP_MID  : 4'hF;
            e_end = (pass == 0) ? EXP_AGED : 4'hF;
            @(negedge clock);
            drive(1'b1, 4'h0, 16'h0000, 1'b0, 4'h0);
            @(negedge clock);
            drive(1'b0, 4'h2, {8'h00, p0, 4'h0}, 1'b0, 4'h0);
            #1;
            check($sformatf("age%0d ack", pass), 32'(bus.ack), 32'h2);
            @(negedge clock);
            drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0);
            #1;
            check($sformatf("age%0d start", pass), 32'(bus.entry[1]), 32'({1'b1, p0}));
            repeat (8) @(negedge clock);
            #1;
            check($sformatf("age%0d mid", pass), 32'(bus.entry[1]), 32'({1'b1, e_mid}));
            repeat (8) @(negedge clock);
            #1;
            check($sformatf("age%0d end", pass), 32'(bus.entry[1]), 32'({1'b1, e_end}));
            check($sformatf("age%0d grant", pass), 32'(bus.grant), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
